// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw line, deserialises 11-bit frames and turns
// set-2 scan codes for the arrow keys and 's' into one-cycle pulses for the game control FSM.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [1:0] direction,
  output logic       dir_valid,
  output logic       start_key,
  output logic       frame_err,
  output logic [7:0] scan_code,
  output logic [4:0] keys_held
);

  localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter fires on the clock edge that would take it to TIMEOUT_CYCLES-1.
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 2);

  localparam int unsigned KeyS = 4;

  typedef enum logic {StIdle, StRecv} state_e;

  logic           r_clk_s1, r_clk_s2, r_clk_prev;
  logic           r_dat_s1, r_dat_s2;
  state_e         r_state, w_state_d;
  logic [3:0]     r_bitcnt, w_bitcnt_d;
  logic [7:0]     r_shift, w_shift_d;
  logic           r_par, w_par_d;
  logic [ToW-1:0] r_to_cnt, w_to_cnt_d;
  logic           r_byte_valid, w_byte_valid_d;
  logic           r_frame_err, w_frame_err_d;
  logic [7:0]     r_scan_code, w_scan_code_d;

  logic           r_ext, w_ext_d;
  logic           r_brk, w_brk_d;
  logic [4:0]     r_held, w_held_d;
  logic [1:0]     r_direction, w_direction_d;
  logic           r_dir_valid, w_dir_valid_d;
  logic           r_start_key, w_start_key_d;

  logic           w_fall;
  logic           w_key_hit;
  logic [2:0]     w_key_idx;

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // Frame receiver
  always_comb begin
    w_state_d      = r_state;
    w_bitcnt_d     = r_bitcnt;
    w_shift_d      = r_shift;
    w_par_d        = r_par;
    w_to_cnt_d     = r_to_cnt;
    w_byte_valid_d = 1'b0;
    w_frame_err_d  = 1'b0;
    w_scan_code_d  = r_scan_code;
    case (r_state)
      StIdle: begin
        w_to_cnt_d = '0;
        if (w_fall && !r_dat_s2) begin
          w_state_d  = StRecv;
          w_bitcnt_d = 4'd0;
          w_par_d    = 1'b0;
        end
      end
      StRecv: begin
        if (w_fall) begin
          w_to_cnt_d = '0;
          if (r_bitcnt == 4'd9) begin
            w_state_d = StIdle;
            // r_par is the XOR of data+parity: 1 means an odd count of ones
            if (r_par && r_dat_s2) begin
              w_byte_valid_d = 1'b1;
              w_scan_code_d  = r_shift;
            end else begin
              w_frame_err_d = 1'b1;
            end
          end else begin
            w_par_d    = r_par ^ r_dat_s2;
            w_bitcnt_d = r_bitcnt + 4'd1;
            if (r_bitcnt < 4'd8) begin
              w_shift_d = {r_dat_s2, r_shift[7:1]};
            end
          end
        end else if (r_to_cnt == ToLast) begin
          w_frame_err_d = 1'b1;
          w_state_d     = StIdle;
          w_to_cnt_d    = '0;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Key index matches the direction encoding for arrows; 's' sits above them.
  always_comb begin
    w_key_hit = 1'b1;
    w_key_idx = 3'd0;
    case ({r_ext, r_scan_code})
      9'h175:  w_key_idx = 3'd0;
      9'h172:  w_key_idx = 3'd1;
      9'h16B:  w_key_idx = 3'd2;
      9'h174:  w_key_idx = 3'd3;
      9'h01B:  w_key_idx = 3'(KeyS);
      default: w_key_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_ext_d       = r_ext;
    w_brk_d       = r_brk;
    w_held_d      = r_held;
    w_direction_d = r_direction;
    w_dir_valid_d = 1'b0;
    w_start_key_d = 1'b0;
    if (r_frame_err) begin
      w_ext_d = 1'b0;
      w_brk_d = 1'b0;
    end else if (r_byte_valid) begin
      if (r_scan_code == 8'hE0) begin
        w_ext_d = 1'b1;
      end else if (r_scan_code == 8'hF0) begin
        w_brk_d = 1'b1;
      end else begin
        w_ext_d = 1'b0;
        w_brk_d = 1'b0;
        if (w_key_hit) begin
          if (r_brk) begin
            w_held_d[w_key_idx] = 1'b0;
          end else if (!r_held[w_key_idx]) begin
            w_held_d[w_key_idx] = 1'b1;
            if (w_key_idx == 3'(KeyS)) begin
              w_start_key_d = 1'b1;
            end else begin
              w_dir_valid_d = 1'b1;
              w_direction_d = w_key_idx[1:0];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_clk_prev   <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_state      <= StIdle;
      r_bitcnt     <= 4'd0;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_scan_code  <= 8'h00;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_held       <= 5'b0;
      r_direction  <= 2'b00;
      r_dir_valid  <= 1'b0;
      r_start_key  <= 1'b0;
    end else begin
      r_clk_s1     <= ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_clk_prev   <= r_clk_s2;
      r_dat_s1     <= ps2_dat;
      r_dat_s2     <= r_dat_s1;
      r_state      <= w_state_d;
      r_bitcnt     <= w_bitcnt_d;
      r_shift      <= w_shift_d;
      r_par        <= w_par_d;
      r_to_cnt     <= w_to_cnt_d;
      r_byte_valid <= w_byte_valid_d;
      r_frame_err  <= w_frame_err_d;
      r_scan_code  <= w_scan_code_d;
      r_ext        <= w_ext_d;
      r_brk        <= w_brk_d;
      r_held       <= w_held_d;
      r_direction  <= w_direction_d;
      r_dir_valid  <= w_dir_valid_d;
      r_start_key  <= w_start_key_d;
    end
  end

  assign direction = r_direction;
  assign dir_valid = r_dir_valid;
  assign start_key = r_start_key;
  assign frame_err = r_frame_err;
  assign scan_code = r_scan_code;
  assign keys_held = r_held;

endmodule
